// File: rtl/mul_hilo_stage_pkg.sv
// Shared CPU definitions for the multiply/HI-LO stage: FSM state encodings
// and register widths.
package mul_hilo_stage_pkg;

    localparam int HILO_W = 32;
    localparam int PROD_W = 2 * HILO_W;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_hilo_stage_hilo.sv
// HI/LO register pair: a product load from the multiplier and independent
// bus moves into either half, with synchronous clear.
module hilo_reg
    import mul_hilo_stage_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              i_prod_ld,
    input  logic [PROD_W-1:0] i_prod,
    input  logic              i_hi_wr,
    input  logic              i_lo_wr,
    input  logic [HILO_W-1:0] i_bus,
    output logic [HILO_W-1:0] o_hi,
    output logic [HILO_W-1:0] o_lo
);

    logic [HILO_W-1:0] r_hi;
    logic [HILO_W-1:0] r_lo;

    // A product load takes priority: a concurrent bus move is dropped.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (i_prod_ld) begin
            r_hi <= i_prod[PROD_W-1:HILO_W];
            r_lo <= i_prod[HILO_W-1:0];
        end else begin
            if (i_hi_wr) r_hi <= i_bus;
            if (i_lo_wr) r_lo <= i_bus;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/mul_hilo_stage.sv
// Multiply sequencing stage: latches operands for an external combinational
// multiplier, waits WAIT_CYCLES for it to settle, then captures into HI/LO.
module mul_hilo_stage
    import mul_hilo_stage_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [HILO_W-1:0] op_a,
    input  logic [HILO_W-1:0] op_b,
    output logic [HILO_W-1:0] mcand,
    output logic [HILO_W-1:0] mplier,
    input  logic [PROD_W-1:0] product,
    input  logic [HILO_W-1:0] bus_in,
    input  logic              hi_wr,
    input  logic              lo_wr,
    output logic [HILO_W-1:0] hi,
    output logic [HILO_W-1:0] lo,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    mul_state_t        r_state;
    mul_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [HILO_W-1:0] r_mcand;
    logic [HILO_W-1:0] r_mplier;
    logic              r_done;
    logic              w_accept;
    logic              w_capture;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (r_cnt == '0) w_state_nxt = CAPTURE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operands only change on acceptance so the multiplier inputs hold
    // steady for the whole settle window.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_capture;
            if (w_accept) begin
                r_mcand  <= op_a;
                r_mplier <= op_b;
            end
        end
    end

    hilo_reg u_hilo (
        .clock     (clock),
        .clear     (clear),
        .i_prod_ld (w_capture),
        .i_prod    (product),
        .i_hi_wr   (hi_wr),
        .i_lo_wr   (lo_wr),
        .i_bus     (bus_in),
        .o_hi      (hi),
        .o_lo      (lo)
    );

    assign mcand  = r_mcand;
    assign mplier = r_mplier;
    assign busy   = (r_state != IDLE);
    assign done   = r_done;

endmodule

// File: tb/tb_mul_hilo_stage.sv
// Scoreboard bench for mul_hilo_stage with a behavioural external multiplier.
module tb_mul_hilo_stage;

    localparam int WAIT_CYCLES = 2;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [63:0] product;
    logic [31:0] bus_in;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_hl;

    always #5 clock = ~clock;

    // External combinational multiplier.
    assign product = {{32{mcand[31]}}, mcand} * {{32{mplier[31]}}, mplier};

    mul_hilo_stage #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clock   (clock),
        .clear   (clear),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .mcand   (mcand),
        .mplier  (mplier),
        .product (product),
        .bus_in  (bus_in),
        .hi_wr   (hi_wr),
        .lo_wr   (lo_wr),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mul64(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        ea = a;
        eb = b;
        return ea * eb;
    endfunction

    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) chk("spurious_done", 64'(done), 64'd0);
            else                   chk("result", {hi, lo}, exp_q.pop_front());
        end
    end

    // mode 0 plain, 1 start poke during SETTLE, 2 hi_wr during CAPTURE,
    // 3 hi_wr+lo_wr together with start
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int mode);
        logic [63:0] e;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        if (mode == 3) begin
            hi_wr  = 1'b1;
            lo_wr  = 1'b1;
            bus_in = 32'hCAFEF00D;
        end
        e = mul64(a, b);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        start = 1'b0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        for (int i = 0; i <= WAIT_CYCLES; i++) begin
            @(negedge clock);
            chk("busy", 64'(busy), 64'd1);
            chk("done_early", 64'(done), 64'd0);
            chk("mcand", 64'(mcand), 64'(a));
            chk("mplier", 64'(mplier), 64'(b));
            if (mode == 3 && i == 0) chk("mv_with_start", {hi, lo}, {2{32'hCAFEF00D}});
            if (mode == 1 && i == 0) begin
                start = 1'b1;
                op_a  = 32'd9;
                @(posedge clock);
                #1 start = 1'b0;
            end
            if (mode == 2 && i == WAIT_CYCLES) begin
                hi_wr  = 1'b1;
                bus_in = 32'h12345678;
                @(posedge clock);
                #1 hi_wr = 1'b0;
            end
        end
        @(negedge clock);
        chk("done", 64'(done), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        last_hl = e;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear  = 1'b1;
        start  = 1'b0;
        op_a   = '0;
        op_b   = '0;
        bus_in = '0;
        hi_wr  = 1'b0;
        lo_wr  = 1'b0;
        repeat (3) @(posedge clock);
        #1 clear = 1'b0;
        @(negedge clock);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_mcand", 64'(mcand), 64'd0);
        chk("rst_mplier", 64'(mplier), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        run_mul(32'd7, -32'sd3, 0);
        chk("neg_small", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        run_mul(32'h80000000, 32'h80000000, 0);
        chk("min_sq", {hi, lo}, 64'h40000000_00000000);
        run_mul(32'd5, 32'd6, 1);
        chk("poke_ignored", {hi, lo}, 64'd30);

        // Back-to-back: each start lands in the previous done cycle.
        run_mul(32'h7FFFFFFF, 32'h80000000, 0);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        for (int n = 0; n < 6; n++) run_mul($urandom, $urandom, 0);

        @(negedge clock);
        bus_in = 32'h12345678;
        hi_wr  = 1'b1;
        @(posedge clock);
        #1 hi_wr = 1'b0;
        @(negedge clock);
        chk("mv_hi", 64'(hi), 64'h12345678);
        chk("mv_hi_lo_kept", 64'(lo), 64'(last_hl[31:0]));
        bus_in = 32'h0BADBEEF;
        lo_wr  = 1'b1;
        @(posedge clock);
        #1 lo_wr = 1'b0;
        @(negedge clock);
        chk("mv_lo", {hi, lo}, 64'h12345678_0BADBEEF);
        bus_in = 32'h55AA55AA;
        hi_wr  = 1'b1;
        lo_wr  = 1'b1;
        @(posedge clock);
        #1;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        @(negedge clock);
        chk("mv_both", {hi, lo}, 64'h55AA55AA_55AA55AA);

        run_mul(-32'sd100000, 32'd300000, 2);
        run_mul(32'd123, -32'sd456, 3);

        // Abort mid-operation with a nonzero HI/LO already held.
        run_mul(-32'sd100000, 32'd300000, 0);
        op_a  = 32'd11;
        op_b  = 32'd13;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        chk("abort_busy_pre", 64'(busy), 64'd1);
        clear = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
        @(negedge clock);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_mcand", 64'(mcand), 64'd0);
        for (int i = 0; i < WAIT_CYCLES + 3; i++) begin
            @(negedge clock);
            chk("abort_no_done", 64'(done), 64'd0);
        end

        // Clear dominates start and moves issued in the same cycle.
        bus_in = 32'hDEADBEEF;
        hi_wr  = 1'b1;
        @(posedge clock);
        #1;
        hi_wr  = 1'b0;
        clear  = 1'b1;
        start  = 1'b1;
        op_a   = 32'd3;
        op_b   = 32'd4;
        hi_wr  = 1'b1;
        lo_wr  = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        start = 1'b0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        @(negedge clock);
        chk("clr_dom_busy", 64'(busy), 64'd0);
        chk("clr_dom_hilo", {hi, lo}, 64'd0);
        chk("clr_dom_mcand", 64'(mcand), 64'd0);
        repeat (WAIT_CYCLES + 2) @(negedge clock);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
